// File: rtl/tft_line_prefetch.sv
// tft_line_prefetch: loads the next display line into a ping-pong line buffer and serves pixels
// to the TFT timing controller. Each line is camera 0 on the left half and camera 1 on the right.
// Ports: clk_in/sys_rst; controller vsync, data_req, pix_x, pix_y -> pix_data (1-cycle latency);
// memory rd_req/rd_addr/rd_len/rd_ack, rd_data_vld/rd_data; sticky underrun/overrun flags.
module tft_line_prefetch #(
    parameter int                H_PIXEL   = 800,
    parameter int                V_PIXEL   = 480,
    parameter int                CAM_W     = 400,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] CAM0_BASE = 24'h000000,
    parameter logic [ADDR_W-1:0] CAM1_BASE = 24'h100000
) (
    input  logic              clk_in,
    input  logic              sys_rst,
    input  logic              vsync,
    input  logic              data_req,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    output logic [15:0]       pix_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [9:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_data_vld,
    input  logic [15:0]       rd_data,
    output logic              underrun,
    output logic              overrun
);

    localparam int               IDX_W  = $clog2(2 * H_PIXEL);
    localparam logic [IDX_W-1:0] H_IDX  = IDX_W'(H_PIXEL);
    localparam logic [10:0]      H_X    = 11'(H_PIXEL);
    localparam logic [9:0]       H_PTR  = 10'(H_PIXEL);
    localparam logic [9:0]       CAM_WL = 10'(CAM_W);
    localparam logic [10:0]      Y_LAST = 11'(V_PIXEL - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ0, S_DAT0, S_REQ1, S_DAT1, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
    logic               tgt_q, tgt_d;
    logic [9:0]         wr_ptr_q, wr_ptr_d;
    logic [9:0]         drain_q, drain_d;
    logic [1:0]         full_q, full_d;
    logic               underrun_q, underrun_d;
    logic               overrun_q, overrun_d;
    logic               vsync_q, data_req_q;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [9:0]         rem;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               frame_trig, req_rise, line_trig;

    // Both banks in one array: bank b occupies [b*H_PIXEL, b*H_PIXEL+H_PIXEL-1].
    logic [15:0] line_mem [0:2*H_PIXEL-1];

    assign frame_trig = vsync & ~vsync_q;
    assign req_rise   = data_req & ~data_req_q;
    assign line_trig  = req_rise && (pix_y < Y_LAST);

    // State register
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            tgt_q       <= 1'b0;
            wr_ptr_q    <= '0;
            drain_q     <= '0;
            full_q      <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            vsync_q     <= 1'b0;
            data_req_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            tgt_q       <= tgt_d;
            wr_ptr_q    <= wr_ptr_d;
            drain_q     <= drain_d;
            full_q      <= full_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            vsync_q     <= vsync;
            data_req_q  <= data_req;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            pix_data_q  <= pix_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        tgt_d       = tgt_q;
        wr_ptr_d    = wr_ptr_q;
        drain_d     = drain_q;
        full_d      = full_q;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;
        rem         = '0;

        case (state_q)
            S_REQ0:  if (rd_ack) state_d = S_DAT0;
            S_DAT0: begin
                if (rd_data_vld) begin
                    wr_ptr_d = wr_ptr_q + 10'd1;
                    if (wr_ptr_q == CAM_WL - 10'd1) state_d = S_REQ1;
                end
            end
            S_REQ1:  if (rd_ack) state_d = S_DAT1;
            S_DAT1: begin
                if (rd_data_vld) begin
                    wr_ptr_d = wr_ptr_q + 10'd1;
                    if (wr_ptr_q == H_PTR - 10'd1) begin
                        state_d        = S_IDLE;
                        full_d[tgt_q]  = 1'b1;
                        line_addr_d    = line_addr_q + ADDR_W'(CAM_W);
                    end
                end
            end
            S_DRAIN: begin
                if (rd_data_vld) begin
                    drain_d = drain_q - 10'd1;
                    if (drain_q == 10'd1) state_d = S_REQ0;
                end
            end
            default: ;
        endcase

        if (req_rise && !full_q[pix_y[0]]) underrun_d = 1'b1;

        if (frame_trig) begin
            // Words still owed by an accepted burst must be swallowed before line 0 is requested.
            case (state_q)
                S_DAT0:         rem = CAM_WL - wr_ptr_q;
                S_DAT1:         rem = H_PTR - wr_ptr_q;
                S_DRAIN:        rem = drain_q;
                S_REQ0, S_REQ1: rem = rd_ack ? CAM_WL : 10'd0;
                default:        rem = 10'd0;
            endcase
            if ((state_q == S_DAT0 || state_q == S_DAT1 || state_q == S_DRAIN) && rd_data_vld)
                rem = rem - 10'd1;
            line_addr_d = '0;
            full_d      = '0;
            tgt_d       = 1'b0;
            wr_ptr_d    = '0;
            drain_d     = rem;
            state_d     = (rem == 10'd0) ? S_REQ0 : S_DRAIN;
        end else if (line_trig) begin
            if (state_q == S_IDLE) begin
                state_d           = S_REQ0;
                tgt_d             = ~pix_y[0];
                full_d[~pix_y[0]] = 1'b0;
                wr_ptr_d          = '0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        rd_req_d  = (state_d == S_REQ0) || (state_d == S_REQ1);
        rd_addr_d = rd_addr_q;
        if (state_d == S_REQ0) rd_addr_d = CAM0_BASE + line_addr_d;
        if (state_d == S_REQ1) rd_addr_d = CAM1_BASE + line_addr_d;

        wr_en  = (state_q == S_DAT0 || state_q == S_DAT1) && rd_data_vld && !frame_trig;
        wr_idx = tgt_q ? (H_IDX + IDX_W'(wr_ptr_q)) : IDX_W'(wr_ptr_q);
        rd_idx = pix_y[0] ? (H_IDX + IDX_W'(pix_x)) : IDX_W'(pix_x);

        pix_data_d = '0;
        if (data_req && (pix_x < H_X)) pix_data_d = line_mem[rd_idx];
    end

    // Buffer storage carries no reset; validity is tracked by full_q.
    always_ff @(posedge clk_in) begin
        if (wr_en) line_mem[wr_idx] <= rd_data;
    end

    assign pix_data = pix_data_q;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign rd_len   = CAM_WL;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_tft_line_prefetch.sv
module tb_tft_line_prefetch;

    localparam int CAM_W = 400;
    localparam int BIG   = 1 << 30;

    logic        clk_in = 1'b0;
    logic        sys_rst;
    logic        vsync;
    logic        data_req;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [15:0] pix_data;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [9:0]  rd_len;
    logic        rd_ack;
    logic        rd_data_vld;
    logic [15:0] rd_data;
    logic        underrun;
    logic        overrun;

    always #5 clk_in = ~clk_in;

    tft_line_prefetch dut (
        .clk_in      (clk_in),
        .sys_rst     (sys_rst),
        .vsync       (vsync),
        .data_req    (data_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_ack      (rd_ack),
        .rd_data_vld (rd_data_vld),
        .rd_data     (rd_data),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int ex; int due; } sb_t;
    sb_t         sbq[$];
    logic [23:0] exp_addr[$];

    // Memory model state
    int          pend      = 0;
    logic [23:0] cur_addr  = '0;
    bit          ack_en    = 1'b1;
    int          allow     = BIG;
    int          delivered = 0;
    int          req_cyc   = 0;

    typedef struct { int x; int y; bit req; int ex; } vec_t;
    vec_t tbl[12];

    int ml_addr;
    int mark;

    task automatic chk(input string name, input int act, input int ex);
        tests++;
        if (act != ex) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, ex, ex);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (a >= 24'h100000) return 16'(1000 + int'(a - 24'h100000));
        return a[15:0];
    endfunction

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Pixel scoreboard: each entry is due on the cycle after it was driven.
    initial forever begin
        @(negedge clk_in);
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk("pix_data", int'(pix_data), e.ex);
        end
    end

    // Memory responder: acks one request at a time, then streams CAM_W words.
    initial begin
        rd_ack = 1'b0; rd_data_vld = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk_in); #1;
            rd_ack = 1'b0; rd_data_vld = 1'b0;
            if (rd_req) req_cyc++;
            if (pend > 0) begin
                if (allow > 0) begin
                    rd_data_vld = 1'b1;
                    rd_data     = mem_word(cur_addr);
                    cur_addr    = cur_addr + 24'd1;
                    pend--; allow--; delivered++;
                end
            end else if (rd_req && ack_en) begin
                rd_ack = 1'b1;
                if (exp_addr.size() == 0) chk("unexpected_req", int'(rd_addr), -1);
                else chk("req_addr", int'(rd_addr), int'(exp_addr.pop_front()));
                chk("req_len", int'(rd_len), CAM_W);
                cur_addr = rd_addr;
                pend     = CAM_W;
            end
        end
    end

    task automatic drive(input int x, input int y, input bit req, input int ex);
        @(posedge clk_in); #1;
        pix_x = 11'(x); pix_y = 11'(y); data_req = req;
        sbq.push_back('{ex: ex, due: cyc + 1});
    endtask

    task automatic wait_idle(input string tag);
        int stable = 0;
        for (int i = 0; i < 5000 && stable < 3; i++) begin
            @(posedge clk_in); #1;
            if (pend == 0 && !rd_req && exp_addr.size() == 0) stable++;
            else stable = 0;
        end
        chk(tag, stable, 3);
    endtask

    task automatic wait_delivered(input int n, input string tag);
        int i = 0;
        while ((delivered - mark) < n && i < 5000) begin
            @(posedge clk_in); #1;
            i++;
        end
        chk(tag, delivered - mark, n);
    endtask

    task automatic push_line(input int a);
        exp_addr.push_back(24'(a));
        exp_addr.push_back(24'(24'h100000 + a));
    endtask

    initial begin
        // {x, y, req, expected pix_data}
        tbl[0]  = '{0,    0, 1'b1, 0};
        tbl[1]  = '{399,  0, 1'b1, 399};
        tbl[2]  = '{400,  0, 1'b1, 1000};
        tbl[3]  = '{799,  0, 1'b1, 1399};
        tbl[4]  = '{800,  0, 1'b1, 0};
        tbl[5]  = '{2047, 0, 1'b1, 0};
        tbl[6]  = '{123,  0, 1'b1, 123};
        tbl[7]  = '{5,    0, 1'b0, 0};
        tbl[8]  = '{0,    1, 1'b1, 400};
        tbl[9]  = '{450,  1, 1'b1, 1450};
        tbl[10] = '{799,  1, 1'b1, 1799};
        tbl[11] = '{300,  1, 1'b0, 0};

        sys_rst = 1'b1; vsync = 1'b0; data_req = 1'b0; pix_x = '0; pix_y = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_rd_req",   int'(rd_req), 0);
        chk("rst_rd_addr",  int'(rd_addr), 0);
        chk("rst_rd_len",   int'(rd_len), CAM_W);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_overrun",  int'(overrun), 0);
        sys_rst = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("post_rst_rd_req", int'(rd_req), 0);

        // Frame trigger loads line 0 into bank 0.
        push_line(0);
        vsync = 1'b1;
        wait_idle("frame0_load_idle");
        vsync = 1'b0;
        ml_addr = CAM_W;

        for (int i = 0; i < 12; i++) begin
            if (i == 0 || tbl[i].y != tbl[i-1].y) begin
                if (i != 0) begin
                    drive(0, tbl[i-1].y, 1'b0, 0);
                    wait_idle("line_load_idle");
                end
                push_line(ml_addr);
                ml_addr += CAM_W;
            end
            drive(tbl[i].x, tbl[i].y, tbl[i].req, tbl[i].ex);
        end
        wait_idle("line2_load_idle");
        chk("no_underrun_normal", int'(underrun), 0);
        chk("no_overrun_normal",  int'(overrun), 0);

        // Last line issues no request.
        mark = req_cyc;
        drive(0, 479, 1'b1, 400);
        drive(0, 479, 1'b0, 0);
        repeat (20) @(posedge clk_in);
        #1;
        chk("last_line_no_req", req_cyc - mark, 0);

        // Memory stalls: line 3 request hangs, second trigger overruns and underruns.
        ack_en = 1'b0;
        drive(0, 2, 1'b1, 800);
        drive(0, 2, 1'b0, 0);
        repeat (4) @(posedge clk_in);
        #1;
        chk("stall_rd_req",  int'(rd_req), 1);
        chk("stall_rd_addr", int'(rd_addr), 1200);
        drive(0, 3, 1'b1, 400);
        drive(0, 3, 1'b0, 0);
        repeat (5) @(posedge clk_in);
        #1;
        chk("underrun_set", int'(underrun), 1);
        chk("overrun_set",  int'(overrun), 1);
        chk("overrun_addr_hold", int'(rd_addr), 1200);
        repeat (20) @(posedge clk_in);
        #1;
        chk("underrun_sticky", int'(underrun), 1);

        // vsync with 100 words of an accepted burst outstanding.
        exp_addr.push_back(24'd1200);
        mark = delivered; allow = 300; ack_en = 1'b1;
        wait_delivered(300, "partial_burst_words");
        repeat (5) @(posedge clk_in);
        push_line(0);
        @(posedge clk_in); #1;
        vsync = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        chk("drain_no_req", int'(rd_req), 0);
        mark = delivered; allow = BIG;
        for (int i = 0; i < 2000 && !rd_req; i++) begin
            @(posedge clk_in); #1;
        end
        chk("drain_words", delivered - mark, 100);
        wait_idle("frame_reload_idle");
        vsync = 1'b0;
        push_line(400);
        drive(10,  0, 1'b1, 10);
        drive(410, 0, 1'b1, 1010);
        drive(0,   0, 1'b0, 0);
        wait_idle("reload_line1_idle");

        // Reset in the middle of the camera 1 burst of line 2.
        push_line(800);
        mark = delivered; allow = 450;
        drive(0, 1, 1'b1, 400);
        drive(0, 1, 1'b0, 0);
        wait_delivered(450, "dat1_words");
        repeat (2) @(posedge clk_in);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("midrst_rd_req",   int'(rd_req), 0);
        chk("midrst_rd_addr",  int'(rd_addr), 0);
        chk("midrst_pix_data", int'(pix_data), 0);
        chk("midrst_underrun", int'(underrun), 0);
        chk("midrst_overrun",  int'(overrun), 0);
        @(posedge clk_in); #1;
        sys_rst = 1'b0;
        ack_en = 1'b0; allow = BIG; mark = req_cyc;
        for (int i = 0; i < 1000 && pend > 0; i++) begin
            @(posedge clk_in); #1;
        end
        chk("post_rst_drained", pend, 0);
        chk("post_rst_no_req", req_cyc - mark, 0);
        drive(10,  0, 1'b1, 810);
        drive(420, 0, 1'b1, 1820);
        drive(500, 0, 1'b1, 1100);
        drive(0,   0, 1'b0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        chk("post_rst_underrun", int'(underrun), 1);
        chk("post_rst_overrun",  int'(overrun), 0);
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tft_line_prefetch.md
Name: tft_line_prefetch

Overview:
- Upstream pixel source for the TFT timing controller.
- Prefetches one display line ahead from frame-buffer memory into a ping-pong line buffer. Each line is composed side-by-side: the left half comes from camera 0's frame, the right half from camera 1's frame.
- Returns pixel data one clock after each data request. This matches the controller's one-cycle-early request window.

Parameters:
H_PIXEL, 800, displayed pixels per line (must be even)
V_PIXEL, 480, displayed lines per frame
CAM_W, 400, words per camera source line (= H_PIXEL/2)
ADDR_W, 24, memory word-address width
CAM0_BASE, 24'h000000, word address of camera 0 frame line 0
CAM1_BASE, 24'h100000, word address of camera 1 frame line 0

Ports:
clk_in  in  1  pixel clock, same clock as the TFT controller
sys_rst  in  1  asynchronous, active-high reset
vsync  in  1  controller frame sync, active high
data_req  in  1  controller pixel request
pix_x  in  11  requested column, valid while data_req=1
pix_y  in  11  requested line, valid while data_req=1
pix_data  out  16  RGB565 pixel for the previous cycle's request
rd_req  out  1  burst read request
rd_addr  out  ADDR_W  burst start word address
rd_len  out  10  burst length in words (= CAM_W)
rd_ack  in  1  one-cycle acceptance of rd_req
rd_data_vld  in  1  read word valid
rd_data  in  16  read word
underrun  out  1  sticky: a line started before its fill completed
overrun  out  1  sticky: a load trigger arrived while the FSM was busy

Behaviour:
- Reset:
  - pix_data=0, rd_req=0, rd_addr=0, rd_len=CAM_W, underrun=0, overrun=0.
  - FSM=IDLE; line_addr=0; both bank_full flags=0.
  - Reset mid-burst abandons the burst and drops rd_req the same cycle. Any rd_data_vld after reset is ignored until the next accepted request.
- Buffer:
  - Two banks of H_PIXEL x 16.
  - Bank b is written at positions [0, CAM_W-1] from camera 0 and [CAM_W, H_PIXEL-1] from camera 1.
- Read path:
  - Display bank = pix_y[0].
  - When data_req=1, pix_data <= bank[pix_y[0]][pix_x] on the next clock (latency exactly 1).
  - When data_req=0, pix_data <= 0 on the next clock.
  - pix_x >= H_PIXEL reads as 0.
- Triggers:
  - Frame trigger, on the vsync rising edge (registered edge detect):
    - line_addr := 0; clears bank_full[0] and bank_full[1].
    - Loads line 0 into bank 0.
  - Line trigger, on the data_req rising edge with pix_y = y < V_PIXEL-1:
    - Loads line y+1 into bank (y+1)&1; clears that bank's full flag.
    - No line trigger when y = V_PIXEL-1.
  - Underrun check at the data_req rising edge: if bank_full[pix_y[0]]=0, set underrun. Pixels are still served from the stale bank contents.
  - A trigger while FSM != IDLE sets overrun and is dropped. The exception is a frame trigger: it aborts the current load, waits for any outstanding words of an already-acked burst to drain and discards them, then starts line 0.
- Load FSM: IDLE -> REQ0 -> DAT0 -> REQ1 -> DAT1 -> IDLE.
  - REQ0: rd_req=1, rd_addr=CAM0_BASE+line_addr, held stable until rd_ack. On rd_ack, rd_req drops in the same cycle's registered output, i.e. it is deasserted the next cycle.
  - DAT0: each rd_data_vld writes bank[tgt][wr_ptr], wr_ptr starting at 0; advance after CAM_W words.
  - REQ1/DAT1: same as REQ0/DAT0 with CAM1_BASE+line_addr, wr_ptr starting at CAM_W.
  - At the end of DAT1: bank_full[tgt]=1; line_addr += CAM_W, with ADDR_W wrap-around permitted.
- Stall rule: the memory side may stall rd_ack and rd_data_vld arbitrarily; the FSM waits indefinitely.
- Collision rule: a write and a read of the same bank in the same cycle is legal. The write never targets the display bank during normal flow.

Test Plan:
- Reset then vsync rise:
  - rd_req=1 with rd_addr=0x000000; after ack and 400 words, rd_req=1 with rd_addr=0x100000.
  - After 400 more words, bank_full[0]=1.
- Fill bank 0 with cam0 words 0..399 and cam1 words 1000..1399; request pix_x=0, 399, 400, 799 on line 0:
  - pix_data one cycle later = 0, 399, 1000, 1399.
  - data_req=0 gives pix_data=0 next cycle.
- data_req rise on line 0:
  - Next bursts use addresses 400 and 0x100190 targeting bank 1.
  - Line 479 issues no request.
- Memory never acks, then line 1 starts: underrun=1, stays 1 until reset.
- Second line trigger during an active load: overrun=1, no extra request. vsync rise mid-DAT0 with 100 words still pending: those 100 words are discarded, then rd_addr=0 is requested.
- Assert sys_rst during DAT1: rd_req=0, outputs return to their reset values, no bank write on the subsequent rd_data_vld pulses.
